// File: rtl/adpll_pkg.sv
// adpll_pkg: shared types and constants for the ADPLL reference-clock generator and phase detector.
// Contents:
//   refgen_state_t  - reference generator state (IDLE, RUN, DRAIN)
//   MIN_PERIOD      - smallest period the generator will produce
//   REF_*_WIDTH     - default widths shared with the phase detector
package adpll_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } refgen_state_t;

    localparam int MIN_PERIOD       = 2;
    localparam int REF_PERIOD_WIDTH = 12;
    localparam int REF_STEP_WIDTH   = 8;

endpackage

// File: rtl/ref_period_counter.sv
// ref_period_counter: period counter, wrap detect and registered square-wave compare.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   en        - counter runs while high, held at 0 otherwise
//   len       - length of the current period in cycles
//   half      - number of high cycles at the start of each period
//   wrap      - combinational, high on the last cycle of a period
//   ref_clk   - registered waveform, one cycle behind the counter
//   rise      - registered pulse aligned with the rising edge of ref_clk
module ref_period_counter
    import adpll_pkg::*;
#(
    parameter int PERIOD_WIDTH = REF_PERIOD_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [PERIOD_WIDTH-1:0] len,
    input  logic [PERIOD_WIDTH-1:0] half,
    output logic                    wrap,
    output logic                    ref_clk,
    output logic                    rise
);

    logic [PERIOD_WIDTH-1:0] cnt_q;

    assign wrap = en && (cnt_q == len - 1'b1);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            ref_clk <= 1'b0;
            rise    <= 1'b0;
        end else begin
            cnt_q   <= (!en || wrap) ? '0 : cnt_q + 1'b1;
            ref_clk <= en && (cnt_q < half);
            rise    <= en && (cnt_q == '0);
        end
    end

endmodule

// File: rtl/ref_clk_gen.sv
// ref_clk_gen: programmable glitch-free reference clock for the ADPLL, with period and phase-step handshakes.
// Ports:
//   fpga_clk_i, reset_i            - clock, synchronous active-high reset
//   enable_i                       - level-sensitive run request
//   period_i/_valid_i/_ready_o     - new nominal period (values below 2 act as 2)
//   step_i/_valid_i/_ready_o       - signed one-period phase step
//   ref_clk_o                      - generated reference clock (registered)
//   ref_rise_o                     - pulse in the cycle ref_clk_o goes high
//   active_o                       - generator is running or draining its last period
module ref_clk_gen
    import adpll_pkg::*;
#(
    parameter int                      PERIOD_WIDTH   = REF_PERIOD_WIDTH,
    parameter int                      STEP_WIDTH     = REF_STEP_WIDTH,
    parameter logic [PERIOD_WIDTH-1:0] DEFAULT_PERIOD = 12'd512
) (
    input  logic                         fpga_clk_i,
    input  logic                         reset_i,
    input  logic                         enable_i,
    input  logic [PERIOD_WIDTH-1:0]      period_i,
    input  logic                         period_valid_i,
    output logic                         period_ready_o,
    input  logic signed [STEP_WIDTH-1:0] step_i,
    input  logic                         step_valid_i,
    output logic                         step_ready_o,
    output logic                         ref_clk_o,
    output logic                         ref_rise_o,
    output logic                         active_o
);

    // two guard bits keep period + step free of overflow before saturation
    localparam int                     AW      = PERIOD_WIDTH + 2;
    localparam logic signed [AW-1:0]   LEN_MAX = AW'((1 << PERIOD_WIDTH) - 1);

    refgen_state_t                state_q, state_d;
    logic                         upd, wrap;
    logic [PERIOD_WIDTH-1:0]      period_q, half_q, len_q, pend_period_q;
    logic [PERIOD_WIDTH-1:0]      period_clamped, period_nxt, half_nxt, len_nxt;
    logic signed [STEP_WIDTH-1:0] pend_step_q;
    logic                         pend_period_valid, pend_step_valid;
    logic signed [AW-1:0]         step_ext, sum, len_lo;

    assign period_ready_o = !pend_period_valid;
    assign step_ready_o   = !pend_step_valid;

    assign period_clamped = (period_i < PERIOD_WIDTH'(MIN_PERIOD)) ? PERIOD_WIDTH'(MIN_PERIOD) : period_i;

    // update applied at a wrap that continues running, or at the start
    assign period_nxt = pend_period_valid ? pend_period_q : period_q;
    assign half_nxt   = period_nxt >> 1;
    assign step_ext   = pend_step_valid ? AW'(pend_step_q) : '0;
    assign sum        = $signed({2'b00, period_nxt}) + step_ext;
    assign len_lo     = $signed({2'b00, half_nxt}) + $signed(AW'(1));
    assign len_nxt    = (sum < len_lo) ? len_lo[PERIOD_WIDTH-1:0] :
                        (sum > LEN_MAX) ? LEN_MAX[PERIOD_WIDTH-1:0] : sum[PERIOD_WIDTH-1:0];

    // a stop request sampled on the wrap cycle ends the run right there,
    // since the current period is already complete
    always_comb begin
        state_d = state_q;
        upd     = 1'b0;
        case (state_q)
            IDLE: begin
                upd     = enable_i;
                state_d = enable_i ? RUN : IDLE;
            end
            RUN: begin
                upd     = wrap && enable_i;
                state_d = enable_i ? RUN : (wrap ? IDLE : DRAIN);
            end
            DRAIN: begin
                upd     = wrap && enable_i;
                state_d = wrap ? (enable_i ? RUN : IDLE) : DRAIN;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge fpga_clk_i) begin
        if (reset_i) begin
            state_q           <= IDLE;
            period_q          <= DEFAULT_PERIOD;
            half_q            <= DEFAULT_PERIOD >> 1;
            len_q             <= DEFAULT_PERIOD;
            pend_period_q     <= '0;
            pend_step_q       <= '0;
            pend_period_valid <= 1'b0;
            pend_step_valid   <= 1'b0;
            active_o          <= 1'b0;
        end else begin
            state_q  <= state_d;
            active_o <= state_q != IDLE;
            if (upd) begin
                period_q <= period_nxt;
                half_q   <= half_nxt;
                len_q    <= len_nxt;
            end
            // accept only when empty, consume only when full: the two never coincide
            pend_period_valid <= pend_period_valid ? !upd : period_valid_i;
            pend_step_valid   <= pend_step_valid ? !upd : step_valid_i;
            if (period_valid_i && period_ready_o)
                pend_period_q <= period_clamped;
            if (step_valid_i && step_ready_o)
                pend_step_q <= step_i;
        end
    end

    ref_period_counter #(
        .PERIOD_WIDTH(PERIOD_WIDTH)
    ) u_counter (
        .clk    (fpga_clk_i),
        .rst    (reset_i),
        .en     (state_q != IDLE),
        .len    (len_q),
        .half   (half_q),
        .wrap   (wrap),
        .ref_clk(ref_clk_o),
        .rise   (ref_rise_o)
    );

endmodule

// File: tb/tb_ref_clk_gen.sv
// tb_ref_clk_gen: directed and randomized bench for ref_clk_gen against a period-level waveform model.
module tb_ref_clk_gen;

    logic              clk = 1'b0;
    logic              reset_i = 1'b1;
    logic              enable_i = 1'b0;
    logic [11:0]       period_i = '0;
    logic              period_valid_i = 1'b0;
    logic              period_ready_o;
    logic signed [7:0] step_i = '0;
    logic              step_valid_i = 1'b0;
    logic              step_ready_o;
    logic              ref_clk_o, ref_rise_o, active_o;

    int n_checks = 0;
    int n_fail   = 0;

    // model: the expected output stream of the current period as a queue of bits
    bit m_wave[$];
    bit m_run, m_first, m_pv, m_sv;
    int m_period, m_pp, m_ps;
    bit e_clk, e_rise, e_active;

    always #5 clk = ~clk;

    ref_clk_gen dut (
        .fpga_clk_i    (clk),
        .reset_i       (reset_i),
        .enable_i      (enable_i),
        .period_i      (period_i),
        .period_valid_i(period_valid_i),
        .period_ready_o(period_ready_o),
        .step_i        (step_i),
        .step_valid_i  (step_valid_i),
        .step_ready_o  (step_ready_o),
        .ref_clk_o     (ref_clk_o),
        .ref_rise_o    (ref_rise_o),
        .active_o      (active_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // build one period from the rules: apply pending period, add pending step, clamp
    task automatic new_period();
        int l, h;
        if (m_pv) begin
            m_period = (m_pp < 2) ? 2 : m_pp;
            m_pv = 0;
        end
        l = m_period + (m_sv ? m_ps : 0);
        m_sv = 0;
        h = m_period / 2;
        if (l < h + 1) l = h + 1;
        if (l > 4095) l = 4095;
        m_wave.delete();
        for (int i = 0; i < l; i++) m_wave.push_back(i < h);
        m_first = 1;
    endtask

    task automatic tick();
        bit old_pv, old_sv, done;
        @(posedge clk);
        if (reset_i) begin
            m_wave.delete();
            m_run = 0; m_first = 0; m_pv = 0; m_sv = 0;
            m_period = 512;
            e_clk = 0; e_rise = 0; e_active = 0;
        end else begin
            old_pv = m_pv;
            old_sv = m_sv;
            e_active = m_run;
            if (m_run) begin
                e_clk = m_wave.pop_front();
                e_rise = m_first;
                m_first = 0;
                done = m_wave.size() == 0;
            end else begin
                e_clk = 0;
                e_rise = 0;
                done = 1;
            end
            if (done) begin
                if (enable_i) begin
                    new_period();
                    m_run = 1;
                end else
                    m_run = 0;
            end
            if (!old_pv && period_valid_i) begin m_pp = int'(period_i); m_pv = 1; end
            if (!old_sv && step_valid_i) begin m_ps = int'(step_i); m_sv = 1; end
        end
        #1;
        check("ref_clk", ref_clk_o, e_clk);
        check("ref_rise", ref_rise_o, e_rise);
        check("active", active_o, e_active);
        check("period_ready", period_ready_o, !m_pv);
        check("step_ready", step_ready_o, !m_sv);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic put_period(input int v);
        bit ack;
        period_i = v[11:0];
        period_valid_i = 1;
        for (int i = 0; i < 20000; i++) begin
            ack = !m_pv;
            tick();
            if (ack) break;
        end
        check("period_accept", !m_pv ? 0 : 1, 1);
        period_valid_i = 0;
    endtask

    task automatic put_step(input int v);
        bit ack;
        step_i = v[7:0];
        step_valid_i = 1;
        for (int i = 0; i < 20000; i++) begin
            ack = !m_sv;
            tick();
            if (ack) break;
        end
        check("step_accept", !m_sv ? 0 : 1, 1);
        step_valid_i = 0;
    endtask

    // wait until the model has just started a fresh period (bounded)
    task automatic to_boundary();
        for (int i = 0; i < 20000; i++) begin
            tick();
            if (m_first && m_run) return;
        end
        check("boundary_timeout", 0, 1);
    endtask

    initial begin
        int r;
        run(3);
        check("rst_clk", ref_clk_o, 0);
        check("rst_rise", ref_rise_o, 0);
        check("rst_active", active_o, 0);
        check("rst_pready", period_ready_o, 1);
        check("rst_sready", step_ready_o, 1);
        reset_i = 0;
        run(2);
        enable_i = 1;
        run(2);
        check("first_rise", ref_rise_o, 1);
        check("first_clk", ref_clk_o, 1);
        check("first_active", active_o, 1);
        run(1100);
        put_period(101);
        check("pready_fall", period_ready_o, 0);
        run(800);
        put_period(100);
        to_boundary();
        to_boundary();
        put_step(7);
        run(350);
        put_step(-60);
        run(300);
        to_boundary();
        period_i = 12'd200; period_valid_i = 1;
        step_i = 8'sd7; step_valid_i = 1;
        tick();
        period_valid_i = 0; step_valid_i = 0;
        run(700);
        put_period(1);
        run(40);
        put_period(20);
        to_boundary();
        run(5);
        enable_i = 0;
        run(5);
        enable_i = 1;
        run(60);
        enable_i = 0;
        run(60);
        check("stopped_clk", ref_clk_o, 0);
        check("stopped_active", active_o, 0);
        enable_i = 1;
        run(50);
        put_period(40);
        for (int i = 0; i < 100 && !(e_clk && m_wave.size() > 0 && m_wave[0]); i++) tick();
        reset_i = 1;
        tick();
        check("rst_mid_clk", ref_clk_o, 0);
        check("rst_mid_pready", period_ready_o, 1);
        reset_i = 0;
        run(1100);
        put_period(4095);
        to_boundary();
        put_step(100);
        run(12400);
        reset_i = 1;
        tick();
        reset_i = 0;
        for (int i = 0; i < 5000; i++) begin
            if ($urandom_range(0, 199) == 0) enable_i = !enable_i;
            reset_i = ($urandom_range(0, 1499) == 0);
            period_valid_i = ($urandom_range(0, 7) == 0);
            period_i = 12'($urandom_range(0, 30));
            step_valid_i = ($urandom_range(0, 7) == 0);
            r = int'($urandom_range(0, 40)) - 20;
            step_i = r[7:0];
            tick();
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
